// File: rtl/nexi_bus_pkg.sv
// rtl/nexi_bus_pkg.sv - shared constants, state encodings and helpers for the bus arbiter
package nexi_bus_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TOERR = 2'd2;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nexi_rr_arbiter.sv
// rtl/nexi_rr_arbiter.sv - combinational round-robin picker starting after the last owner
module nexi_rr_arbiter
  import nexi_bus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan last+1 .. last+NUM_REQ so the previous owner is considered last.
  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand     = (int'(last_i) + off) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o         = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/nexi_bus_arbiter.sv
// rtl/nexi_bus_arbiter.sv - round-robin wishbone arbiter with per-transfer watchdog
module nexi_bus_arbiter
  import nexi_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int TIMEOUT     = 255
) (
  input  logic                            clk_i,
  input  logic                            reset_ni,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_i,
  output logic [DATA_WIDTH-1:0]           m_data_o,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_sel_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic [NUM_MASTERS-1:0]          m_rty_o,
  output logic [ADDR_WIDTH-1:0]           s_addr_o,
  output logic [DATA_WIDTH-1:0]           s_data_o,
  input  logic [DATA_WIDTH-1:0]           s_data_i,
  output logic                            s_cyc_o,
  output logic                            s_sel_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  input  logic                            s_ack_i,
  input  logic                            s_err_i,
  input  logic                            s_rty_i,
  output logic [NUM_MASTERS-1:0]          gnt_o
);

  localparam int               IDX_W      = clog2(NUM_MASTERS);
  localparam int               WD_W_RAW   = clog2(TIMEOUT + 1);
  localparam int               WD_W       = (WD_W_RAW < 1) ? 1 : WD_W_RAW;
  localparam bit               WD_EN      = (TIMEOUT != 0);
  localparam logic [WD_W-1:0]  WD_LIMIT   = WD_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_MASTERS - 1);

  logic [1:0]             state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [WD_W-1:0]        wd_q, wd_d;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;

  logic                   own_cyc, own_sel, own_stb, own_we;
  logic [ADDR_WIDTH-1:0]  own_addr;
  logic [DATA_WIDTH-1:0]  own_data;
  logic                   granted, bus_term;

  nexi_rr_arbiter #(
    .NUM_REQ (NUM_MASTERS),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i   (m_cyc_i),
    .last_i  (last_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    own_cyc  = 1'b0;
    own_sel  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_addr = '0;
    own_data = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (owner_q == IDX_W'(k)) begin
        own_cyc  = m_cyc_i[k];
        own_sel  = m_sel_i[k];
        own_stb  = m_stb_i[k];
        own_we   = m_we_i[k];
        own_addr = m_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        own_data = m_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign granted  = (state_q == ST_GRANT);
  assign bus_term = s_ack_i | s_err_i | s_rty_i;

  assign s_cyc_o  = granted & own_cyc;
  assign s_sel_o  = granted & own_sel;
  assign s_stb_o  = granted & own_stb;
  assign s_we_o   = granted & own_we;
  assign s_addr_o = granted ? own_addr : '0;
  assign s_data_o = granted ? own_data : '0;

  // Terminations reach only the owner; TOERR substitutes a one-cycle err.
  assign m_ack_o  = granted ? (gnt_q & {NUM_MASTERS{s_ack_i}}) : '0;
  assign m_rty_o  = granted ? (gnt_q & {NUM_MASTERS{s_rty_i}}) : '0;
  assign m_err_o  = granted ? (gnt_q & {NUM_MASTERS{s_err_i}}) :
                    (state_q == ST_TOERR) ? gnt_q : '0;
  assign m_data_o = s_data_i;
  assign gnt_o    = gnt_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    wd_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          owner_d = pick_idx;
          gnt_d   = pick_gnt;
        end
      end
      ST_GRANT: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
          gnt_d   = '0;
        end else if (WD_EN && s_stb_o && !bus_term) begin
          wd_d = (wd_q == WD_LIMIT) ? wd_q : wd_q + 1'b1;
          if (wd_d == WD_LIMIT) begin
            state_d = ST_TOERR;
          end
        end
      end
      ST_TOERR: begin
        state_d = ST_IDLE;
        last_d  = owner_q;
        gnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= LAST_RESET;
      gnt_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: doc/nexi_bus_arbiter.md
Name: nexi_bus_arbiter

Overview:
Shares the single shared wishbone bus between NUM_MASTERS cache bus-master ports, one per CPU/cache pair.
- Arbitration is round-robin. Each grant is held for a whole wishbone cycle (cyc high).
- A per-transfer watchdog terminates a hung slave with err.
- A one-hot grant vector is exported so each cache's sniffer can ignore its own transfers.

Parameters:
NUM_MASTERS, 2, number of cache bus-master ports (2..8)
ADDR_WIDTH, 32, wishbone address width
DATA_WIDTH, 32, wishbone data width
TIMEOUT, 255, cycles with stb high and no ack/err/rty before forced err; 0 disables the watchdog

Ports:
clk_i  in  1  system clock
reset_ni  in  1  asynchronous active-low reset
m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  packed master addresses; master k at [k*ADDR_WIDTH +: ADDR_WIDTH]
m_data_i  in  NUM_MASTERS*DATA_WIDTH  packed master write data
m_data_o  out  DATA_WIDTH  read data, s_data_i broadcast to all masters
m_cyc_i, m_sel_i, m_stb_i, m_we_i  in  NUM_MASTERS  per-master wishbone controls
m_ack_o, m_err_o, m_rty_o  out  NUM_MASTERS  per-master terminations
s_addr_o  out  ADDR_WIDTH  shared bus address
s_data_o  out  DATA_WIDTH  shared bus write data
s_data_i  in  DATA_WIDTH  shared bus read data
s_cyc_o, s_sel_o, s_stb_o, s_we_o  out  1  shared bus controls
s_ack_i, s_err_i, s_rty_i  in  1  shared bus terminations
gnt_o  out  NUM_MASTERS  one-hot current owner; all-zero when idle

Behaviour:
- Reset (async, reset_ni=0): state=IDLE, gnt_o=0, last owner=NUM_MASTERS-1 (master 0 wins first), watchdog=0. All s_* outputs and m_*_o outputs are 0, m_data_o excepted. Reset mid-transfer abandons the transfer; no err is generated.
- States:
  - IDLE: s_* outputs are 0.
  - GRANT: the owner's signals are routed to the bus.
  - TOERR: one-cycle watchdog abort.
- IDLE -> GRANT:
  - On the edge where any m_cyc_i=1, register the owner: the first requesting index after the last owner, cyclically.
  - Grant latency is 1 cycle: cyc sampled at edge n gives gnt_o and s_cyc_o high from n+1.
- GRANT routing:
  - s_addr/data/cyc/sel/stb/we_o follow the owner's inputs combinationally.
  - s_ack/err/rty_i are routed combinationally to the owner's m_*_o only. Non-owners see 0.
  - Bursts and back-to-back stb within one cyc remain with the owner.
- GRANT -> IDLE:
  - Occurs when the owner's m_cyc_i=0 at a clock edge.
  - Last owner is updated.
  - One mandatory idle cycle (s_cyc_o=0) follows before the next grant; sniffers rely on it.
- Watchdog:
  - Increments each GRANT cycle with s_stb_o=1 and no s_ack_i/s_err_i/s_rty_i.
  - Clears on any termination, on stb low, or on leaving GRANT.
  - When it reaches TIMEOUT: go to TOERR.
  - TOERR cycle: s_cyc_o=s_stb_o=0, m_err_o[owner]=1 for exactly one cycle, then IDLE with last owner updated.
  - Termination arriving on the same cycle the count reaches TIMEOUT: the termination wins, the watchdog clears, no TOERR.
- Simultaneous events:
  - Owner drops cyc in the same cycle a late ack arrives: ack is still forwarded combinationally, and the state returns to IDLE.
  - All masters requesting: strict rotation, no master waits more than NUM_MASTERS-1 grants.
- Width: watchdog is clog2(TIMEOUT+1) bits and saturates; never wraps.

Decomposition:
- Package nexi_bus_pkg:
  - state encodings ST_IDLE, ST_GRANT, ST_TOERR
  - clog2 helper function
  - default ADDR_WIDTH/DATA_WIDTH constants
- Sub-module nexi_rr_arbiter: combinational round-robin picker. Inputs: req vector and last-owner index. Outputs: one-hot winner and binary index.
- The FSM, watchdog and muxes stay in nexi_bus_arbiter.

Test Plan:
- Single master: m_cyc_i=01 at edge 0, read addr 0x1000, slave acks at edge 3 with 0xDEADBEEF -> gnt_o=01 from cycle 1; m_ack_o=01 and m_data_o=0xDEADBEEF at cycle 3; s_cyc_o=0 the cycle after cyc drops.
- Contention, both masters: m_cyc_i=11 continuously, each holds 2 transfers -> grants alternate 01,10,01,10 with exactly one idle cycle between grants; the non-owner never sees ack.
- Watchdog, TIMEOUT=4: owner stb high, slave silent -> m_err_o[owner]=1 for one cycle on the 5th stb cycle; s_cyc_o=0 that cycle; next grant goes to the other master.
- Ack on the timeout boundary: ack on the same cycle the count reaches 4 -> ack forwarded, no err, transfer continues.
- Async reset: reset_ni=0 mid-burst (between clock edges) -> all outputs 0 immediately; after release with m_cyc_i=11, master 0 is granted first.
- Disabled watchdog, TIMEOUT=0: stb held for 1000 cycles with no ack -> no err; grant held throughout.
